id_issue_ctl: RTL and testbench
===============================

# id_issue_ctl

Issue controller that sits beside the ID stage of the five-stage MIPS pipeline. It keeps a per-register result-latency scoreboard and raises `stallreq_o` on read-after-write hazards that forwarding cannot cover, such as load-use and multi-cycle results. It also tracks branch delay slots with a small state machine and counts stall cycles. The ID stage feeds it the already-decoded source and destination fields. Its `stallreq_o` goes to the ctrl block, and its delay-slot flag goes to ID/EX.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers.
- `ADDR_W`, 5: register address width.
- `LAT_W`, 2: width of the latency field. The maximum latency is 2^LAT_W−1.
- `CNT_W`, 32: width of the stall-cycle counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `hold_i` in 1: pipeline frozen by ctrl (ID stage stalled by a downstream stage).
- `flush_i` in 1: pipeline flush. Clears the scoreboard and the delay-slot state.
- `id_valid_i` in 1: the ID stage holds a real instruction.
- `reg1_read_i` in 1: the instruction reads source 1.
- `reg1_addr_i` in ADDR_W: source 1 register address.
- `reg2_read_i` in 1: the instruction reads source 2.
- `reg2_addr_i` in ADDR_W: source 2 register address.
- `wreg_i` in 1: the instruction writes a register.
- `wd_i` in ADDR_W: destination register address.
- `lat_i` in LAT_W: extra cycles before this instruction's result can be forwarded to ID. 0 = ALU, 1 = load.
- `branch_i` in 1: the instruction is a taken branch or jump.
- `stallreq_o` out 1: hazard stall request to ctrl.
- `issue_o` out 1: the instruction advances to EX this cycle.
- `is_in_delayslot_o` out 1: the instruction now in ID is in a delay slot.
- `busy_o` out REG_NUM: one bit per register, set when its counter is non-zero.
- `stall_cycles_o` out CNT_W: saturating count of hazard-stall cycles.

## Operation
Issue and hazard rules:
- `issue_o` = `id_valid_i` & !`stallreq_o` & !`hold_i` & !`flush_i`.
- Scoreboard: one LAT_W down-counter per register, `cnt[r]`.
- Hazard: (`reg1_read_i` & `reg1_addr_i`≠0 & `cnt[reg1_addr_i]`≠0), or the same test on source 2.
- `stallreq_o` = `id_valid_i` & hazard. It is evaluated even while `hold_i` is high.

Scoreboard update, on a clock edge with !`hold_i`:
- Every non-zero counter decrements by 1.
- Then, if `issue_o` & `wreg_i` & `wd_i`≠0, `cnt[wd_i]` is set to `lat_i`. The new value overrides that register's decrement in the same cycle.
- `lat_i`=0 clears any pending count on that register (WAW).
- Register 0 is never marked busy.
- With `hold_i` high, all counters, the FSM and the stall counter hold. Exception: `flush_i` still applies.

Delay-slot FSM, with states IDLE and SLOT:
- IDLE → SLOT: on `issue_o` & `branch_i`.
- SLOT → IDLE: on `issue_o` & !`branch_i`.
- SLOT → SLOT: on `issue_o` & `branch_i`. A branch in a delay slot marks the next instruction as a slot.
- `is_in_delayslot_o` = (state==SLOT).
- `flush_i` forces IDLE and zeroes all counters on the next edge.

Stall counter:
- `stall_cycles_o` increments on each edge with `stallreq_o` & !`hold_i`.
- It saturates at all-ones.

## Timing
- Reset (synchronous): all `cnt` = 0, state = IDLE, `stall_cycles_o` = 0. Consequently `busy_o` = 0, `is_in_delayslot_o` = 0 and `stallreq_o` = 0.
- `stallreq_o`, `issue_o`, `busy_o` and `is_in_delayslot_o` are combinational from the current inputs and registered state, all within the same cycle.
- A producer issued at cycle t with `lat_i`=n makes a dependent instruction in ID stall for cycles t+1 … t+n. The dependent instruction issues at t+n+1. A load therefore costs exactly 1 bubble.
- Reset or flush mid-stall: the stall releases on the first cycle after the edge.

## Structure
- Shared package `mips_pkg`: FSM state encoding (`DS_IDLE`, `DS_SLOT`), latency constants `LAT_ALU`=0 and `LAT_LOAD`=1, and the zero-register address constant.
- Natural sub-module: `sb_counter`, a single-register down-counter with load-override, instantiated REG_NUM times in a generate loop.

## Test plan
- Reset, then an idle cycle: all outputs 0. Check `busy_o`=32'h0.
- `lw $3` (`lat_i`=1) at t, then `addu $4,$3,$5` in ID at t+1: `stallreq_o`=1 at t+1, `issue_o`=1 at t+2, `stall_cycles_o`=1.
- Producer with `lat_i`=3 on `$7`, `hold_i`=1 for 2 cycles, then a consumer of `$7`: `busy_o[7]` stays set during hold. The consumer stalls 3 cycles after the hold drops.
- Writes and reads of `$0` with `lat_i`=3: `busy_o[0]`=0 and no stall.
- `jal` issued (`branch_i`=1): the next instruction sees `is_in_delayslot_o`=1, and the one after sees 0. Repeat with a branch in the slot: the flag stays 1 for the following instruction.
- `lat_i`=2 on `$9`, then `flush_i`=1 with a `$9` consumer in ID: `busy_o[9]`=0 and the FSM is IDLE after the edge. `stallreq_o` drops the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID-stage issue controller: delay-slot state
// encoding, result-latency constants and the hard-wired zero register.
package mips_pkg;

    typedef enum logic [0:0] {
        DS_IDLE = 1'b0,
        DS_SLOT = 1'b1
    } ds_state_e;

    localparam logic [1:0] LAT_ALU  = 2'd0;
    localparam logic [1:0] LAT_LOAD = 2'd1;
    localparam logic [4:0] ZERO_REG = 5'd0;

    // A source operand is hazardous only if it is read, not $0, and still pending.
    function automatic logic src_hazard(input logic rd, input logic addr_nz, input logic pending);
        return rd & addr_nz & pending;
    endfunction

endpackage

// File: rtl/id_issue_ctl_sb_counter.sv
// One scoreboard entry: a down-counter of cycles until the register's pending
// result can be forwarded to ID, with a load that overrides the decrement.
module sb_counter #(
    parameter int LAT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             busy,
    output logic [LAT_W-1:0] cnt
);

    logic [LAT_W-1:0] cnt_r;

    // Count down while the pipeline advances; a new producer replaces the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {LAT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {LAT_W{1'b0}};
        end else if (en) begin
            if (load) begin
                cnt_r <= load_val;
            end else if (cnt_r != {LAT_W{1'b0}}) begin
                cnt_r <= cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign busy = (cnt_r != {LAT_W{1'b0}});

endmodule

// File: rtl/id_issue_ctl.sv
// ID-stage issue controller: latency scoreboard for RAW stalls, branch
// delay-slot tracking and a saturating count of hazard-stall cycles.
module id_issue_ctl
    import mips_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int LAT_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic               reg1_read_i,
    input  logic [ADDR_W-1:0]  reg1_addr_i,
    input  logic               reg2_read_i,
    input  logic [ADDR_W-1:0]  reg2_addr_i,
    input  logic               wreg_i,
    input  logic [ADDR_W-1:0]  wd_i,
    input  logic [LAT_W-1:0]   lat_i,
    input  logic               branch_i,
    output logic               stallreq_o,
    output logic               issue_o,
    output logic               is_in_delayslot_o,
    output logic [REG_NUM-1:0] busy_o,
    output logic [CNT_W-1:0]   stall_cycles_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [REG_NUM-1:0] busy_s;
    logic [LAT_W-1:0]   cnt_s [REG_NUM];
    logic               hazard_s;
    logic               stall_s;
    logic               issue_s;
    logic               wr_en_s;
    ds_state_e          state_r;
    logic [CNT_W-1:0]   stall_cnt_r;

    assign hazard_s = src_hazard(reg1_read_i, reg1_addr_i != ZERO_ADDR, busy_s[reg1_addr_i])
                    | src_hazard(reg2_read_i, reg2_addr_i != ZERO_ADDR, busy_s[reg2_addr_i]);
    assign stall_s  = id_valid_i & hazard_s;
    assign issue_s  = id_valid_i & ~stall_s & ~hold_i & ~flush_i;
    assign wr_en_s  = issue_s & wreg_i & (wd_i != ZERO_ADDR);

    // Entry 0 has no load path, so $0 can never be marked busy.
    for (genvar g = 0; g < REG_NUM; g++) begin : g_sb
        sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush_i),
            .en       (~hold_i),
            .load     (wr_en_s && (wd_i == ADDR_W'(g))),
            .load_val (lat_i),
            .busy     (busy_s[g]),
            .cnt      (cnt_s[g])
        );
    end

    // Delay-slot tracker: the instruction after any issued branch is a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DS_IDLE;
        end else if (flush_i) begin
            state_r <= DS_IDLE;
        end else if (!hold_i) begin
            case (state_r)
                DS_IDLE: state_r <= (issue_s && branch_i)  ? DS_SLOT : DS_IDLE;
                DS_SLOT: state_r <= (issue_s && !branch_i) ? DS_IDLE : DS_SLOT;
                default: state_r <= DS_IDLE;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Hazard-stall cycle counter, frozen with the pipeline and pinned at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && !hold_i && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stallreq_o        = stall_s;
    assign issue_o           = issue_s;
    assign busy_o            = busy_s;
    assign is_in_delayslot_o = (state_r == DS_SLOT);
    assign stall_cycles_o    = stall_cnt_r;

endmodule

// File: tb/tb_id_issue_ctl.sv
// Directed and randomized checks of id_issue_ctl against a reference model that
// tracks, per register, the pipeline-progress time at which its result is ready.
module tb_id_issue_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_i, flush_i, id_valid_i;
    logic        reg1_read_i, reg2_read_i, wreg_i, branch_i;
    logic [4:0]  reg1_addr_i, reg2_addr_i, wd_i;
    logic [1:0]  lat_i;
    logic        stallreq_o, issue_o, is_in_delayslot_o;
    logic [31:0] busy_o, stall_cycles_o;

    id_issue_ctl dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .reg1_read_i(reg1_read_i), .reg1_addr_i(reg1_addr_i),
        .reg2_read_i(reg2_read_i), .reg2_addr_i(reg2_addr_i), .wreg_i(wreg_i),
        .wd_i(wd_i), .lat_i(lat_i), .branch_i(branch_i), .stallreq_o(stallreq_o),
        .issue_o(issue_o), .is_in_delayslot_o(is_in_delayslot_o), .busy_o(busy_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: "prog" counts edges on which the pipeline advanced;
    // a register is pending while its ready time lies in the future.
    longint ready_at [32];
    longint prog;
    longint m_stall_cnt;
    bit     m_slot;

    logic        obs_stall, obs_issue, obs_slot;
    logic [31:0] obs_busy, obs_cnt;

    function automatic logic [31:0] m_busy();
        logic [31:0] b = 32'h0;
        for (int r = 0; r < 32; r++) b[r] = (ready_at[r] > prog);
        return b;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        prog = 0; m_stall_cnt = 0; m_slot = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic v, input logic r1rd, input logic [4:0] r1,
                         input logic r2rd, input logic [4:0] r2, input logic wr,
                         input logic [4:0] wd, input logic [1:0] lat, input logic br,
                         input logic hd, input logic fl);
        logic [31:0] eb;
        logic e_stall, e_issue;
        id_valid_i = v; reg1_read_i = r1rd; reg1_addr_i = r1; reg2_read_i = r2rd;
        reg2_addr_i = r2; wreg_i = wr; wd_i = wd; lat_i = lat; branch_i = br;
        hold_i = hd; flush_i = fl;
        @(negedge clk);
        obs_stall = stallreq_o; obs_issue = issue_o; obs_slot = is_in_delayslot_o;
        obs_busy = busy_o; obs_cnt = stall_cycles_o;
        eb = m_busy();
        e_stall = v && ((r1rd && r1 != 5'd0 && eb[r1]) || (r2rd && r2 != 5'd0 && eb[r2]));
        e_issue = v && !e_stall && !hd && !fl;
        chk("stallreq", {31'h0, obs_stall}, {31'h0, e_stall});
        chk("issue", {31'h0, obs_issue}, {31'h0, e_issue});
        chk("busy", obs_busy, eb);
        chk("delayslot", {31'h0, obs_slot}, {31'h0, m_slot});
        chk("stall_cycles", obs_cnt, m_stall_cnt[31:0]);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_stall && !hd && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            if (fl) begin
                for (int r = 0; r < 32; r++) ready_at[r] = 0;
                m_slot = 1'b0;
            end
            if (!hd) begin
                if (e_issue && wr && wd != 5'd0) ready_at[wd] = prog + lat + 1;
                if (e_issue) m_slot = br;
                prog++;
            end
        end
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [1:0] lat, input logic br, input logic hd, input logic fl);
        apply(1'b1, 1'b1, rs, 1'b1, rt, 1'b1, rd, lat, br, hd, fl);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        idle();
        idle();
        rst = 1'b0;

        // Post-reset idle cycle
        idle();
        chk("reset_busy", obs_busy, 32'h0);
        chk("reset_slot", {31'h0, obs_slot}, 32'h0);
        chk("reset_stall", {31'h0, obs_stall}, 32'h0);
        chk("reset_cnt", obs_cnt, 32'h0);

        // Load-use: exactly one bubble
        alu(5'd0, 5'd0, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("lw_issue", {31'h0, obs_issue}, 32'h1);
        alu(5'd3, 5'd5, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall", {31'h0, obs_stall}, 32'h1);
        alu(5'd3, 5'd5, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_issue", {31'h0, obs_issue}, 32'h1);
        chk("lu_cnt", obs_cnt, 32'h1);

        // Latency 3 with a 2-cycle hold: counters freeze
        alu(5'd0, 5'd0, 5'd7, 2'd3, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("hold_busy7", {31'h0, obs_busy[7]}, 32'h1);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("hold_busy7b", {31'h0, obs_busy[7]}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            alu(5'd7, 5'd1, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
            chk("lat3_stall", {31'h0, obs_stall}, 32'h1);
        end
        alu(5'd7, 5'd1, 5'd8, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("lat3_issue", {31'h0, obs_issue}, 32'h1);
        chk("lat3_cnt", obs_cnt, 32'h4);

        // $0 is never busy
        alu(5'd0, 5'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
        alu(5'd0, 5'd0, 5'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("r0_busy", {31'h0, obs_busy[0]}, 32'h0);
        chk("r0_stall", {31'h0, obs_stall}, 32'h0);

        // Delay slots: single branch, then branch in slot
        alu(5'd0, 5'd0, 5'd31, 2'd0, 1'b1, 1'b0, 1'b0);
        alu(5'd1, 5'd1, 5'd10, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("ds_slot", {31'h0, obs_slot}, 32'h1);
        alu(5'd1, 5'd1, 5'd10, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("ds_after", {31'h0, obs_slot}, 32'h0);
        alu(5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        alu(5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("ds_br_in_slot", {31'h0, obs_slot}, 32'h1);
        alu(5'd1, 5'd1, 5'd10, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("ds_chain", {31'h0, obs_slot}, 32'h1);
        alu(5'd1, 5'd1, 5'd10, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("ds_chain_end", {31'h0, obs_slot}, 32'h0);

        // Flush with a pending consumer
        alu(5'd0, 5'd0, 5'd9, 2'd2, 1'b1, 1'b0, 1'b0);
        alu(5'd9, 5'd0, 5'd11, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("fl_stall", {31'h0, obs_stall}, 32'h1);
        alu(5'd9, 5'd0, 5'd11, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("fl_busy9", {31'h0, obs_busy[9]}, 32'h0);
        chk("fl_slot", {31'h0, obs_slot}, 32'h0);
        chk("fl_release", {31'h0, obs_stall}, 32'h0);

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            apply($urandom_range(0, 9) != 0, 1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 2'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
